// File: rtl/mem_access_seq.sv
// Sequences one fetch/load/store at a time against a synchronous word RAM and
// latches read data into the instruction register (fetch) or the MDR (load).
module mem_access_seq #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              done,
    output logic              addr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       ir,
    output logic [DATA_W-1:0] mdr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm
);

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWr,
        StDone
    } stateT;

    // Counters load LAT-1 so that reaching zero marks the final wait cycle.
    localparam logic [2:0] ReadCnt  = 3'(READ_LAT - 1);
    localparam logic [2:0] WriteCnt = 3'(WRITE_LAT - 1);

    stateT      state;
    logic [2:0] cnt;
    logic       fetchSel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= 3'd0;
            fetchSel  <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            addr_err  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (req_addr[1:0] != 2'b00) begin
                            // Rejected in place: no RAM traffic, stay ready.
                            addr_err <= 1'b1;
                        end else begin
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            fetchSel  <= req_fetch;
                            req_ready <= 1'b0;
                            if (req_write) begin
                                state  <= StWr;
                                cnt    <= WriteCnt;
                                mem_we <= 1'b1;
                            end else begin
                                state <= StRdWait;
                                cnt   <= ReadCnt;
                            end
                        end
                    end
                end
                StRdWait: begin
                    if (cnt == 3'd0) begin
                        if (fetchSel) begin
                            ir <= mem_rdata[31:0];
                        end else begin
                            mdr <= mem_rdata;
                        end
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StWr: begin
                    if (cnt == 3'd0) begin
                        mem_we <= 1'b0;
                        state  <= StDone;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StDone: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two builds (2/1 and 3/2 latencies) checked every cycle
// against a request-level timing model, plus directed scenarios with literal expectations.
module tb_mem_access_seq;

    localparam int RL0 = 2;
    localparam int WL0 = 1;
    localparam int RL1 = 3;
    localparam int WL1 = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid[2];
    logic        reqWrite[2];
    logic        reqFetch[2];
    logic [31:0] reqAddr[2];
    logic [31:0] reqWdata[2];
    logic [31:0] memRdata[2];
    logic        reqReady[2];
    logic        done[2];
    logic        addrErr[2];
    logic        memWe[2];
    logic [31:0] memAddr[2];
    logic [31:0] memWdata[2];
    logic [31:0] ir[2];
    logic [31:0] mdr[2];
    logic [5:0]  opcode[2];
    logic [5:0]  funct[2];
    logic [4:0]  rs[2];
    logic [4:0]  rt[2];
    logic [4:0]  rd[2];
    logic [15:0] imm[2];

    always #5 clk = ~clk;

    mem_access_seq #(
        .ADDR_W(32), .DATA_W(32), .READ_LAT(RL0), .WRITE_LAT(WL0)
    ) dut0 (
        .clk(clk), .reset(reset), .req_valid(reqValid[0]), .req_write(reqWrite[0]),
        .req_fetch(reqFetch[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .req_ready(reqReady[0]), .done(done[0]), .addr_err(addrErr[0]),
        .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]), .mem_we(memWe[0]),
        .mem_rdata(memRdata[0]), .ir(ir[0]), .mdr(mdr[0]), .opcode(opcode[0]),
        .funct(funct[0]), .rs(rs[0]), .rt(rt[0]), .rd(rd[0]), .imm(imm[0])
    );

    mem_access_seq #(
        .ADDR_W(32), .DATA_W(32), .READ_LAT(RL1), .WRITE_LAT(WL1)
    ) dut1 (
        .clk(clk), .reset(reset), .req_valid(reqValid[1]), .req_write(reqWrite[1]),
        .req_fetch(reqFetch[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .req_ready(reqReady[1]), .done(done[1]), .addr_err(addrErr[1]),
        .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]), .mem_we(memWe[1]),
        .mem_rdata(memRdata[1]), .ir(ir[1]), .mdr(mdr[1]), .opcode(opcode[1]),
        .funct(funct[1]), .rs(rs[1]), .rt(rt[1]), .rd(rd[1]), .imm(imm[1])
    );

    // Model: an access accepted at edge T occupies edges T..T+lat; done is seen after edge T+lat.
    bit          mBusy[2];
    int          mT[2];
    bit          mWrite[2];
    bit          mFetch[2];
    bit          mErr[2];
    bit          accepted[2];
    logic [31:0] mIr[2];
    logic [31:0] mMdr[2];
    logic [31:0] mAddr[2];
    logic [31:0] mWdata[2];
    int          edgeCnt = 0;
    int          nCmp = 0;
    int          nBad = 0;

    int tAcc;
    int doneCnt[2];
    int lastDone[2];
    int weCnt[2];
    int firstWe[2];
    int weBad[2];
    int nAcc[2];

    function automatic int rlat(input int i);
        return (i == 0) ? RL0 : RL1;
    endfunction

    function automatic int wlat(input int i);
        return (i == 0) ? WL0 : WL1;
    endfunction

    function automatic int lat(input int i);
        return mWrite[i] ? wlat(i) : rlat(i);
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL dut%0d %s: got 0x%08h, want 0x%08h (edge %0d)", i, name, act, exp,
                     edgeCnt);
        end
    endtask

    task automatic modelEdge(input int i);
        mErr[i]     = 1'b0;
        accepted[i] = 1'b0;
        if (!mBusy[i]) begin
            if (reqValid[i]) begin
                accepted[i] = 1'b1;
                if (reqAddr[i][1:0] != 2'b00) begin
                    mErr[i] = 1'b1;
                end else begin
                    mBusy[i]  = 1'b1;
                    mT[i]     = edgeCnt;
                    mWrite[i] = reqWrite[i];
                    mFetch[i] = reqFetch[i];
                    mAddr[i]  = reqAddr[i];
                    mWdata[i] = reqWdata[i];
                end
            end
        end else begin
            if (!mWrite[i] && edgeCnt == mT[i] + rlat(i)) begin
                if (mFetch[i]) mIr[i] = memRdata[i];
                else mMdr[i] = memRdata[i];
            end
            if (edgeCnt == mT[i] + lat(i) + 1) mBusy[i] = 1'b0;
        end
    endtask

    task automatic compareAll(input int i);
        logic expDone;
        logic expWe;
        expDone = mBusy[i] && (edgeCnt == mT[i] + lat(i));
        expWe   = mBusy[i] && mWrite[i] && (edgeCnt < mT[i] + wlat(i));
        check("req_ready", i, 32'(reqReady[i]), 32'(!mBusy[i]));
        check("done", i, 32'(done[i]), 32'(expDone));
        check("addr_err", i, 32'(addrErr[i]), 32'(mErr[i]));
        check("mem_we", i, 32'(memWe[i]), 32'(expWe));
        check("mem_addr", i, memAddr[i], mAddr[i]);
        check("mem_wdata", i, memWdata[i], mWdata[i]);
        check("ir", i, ir[i], mIr[i]);
        check("mdr", i, mdr[i], mMdr[i]);
        check("opcode", i, 32'(opcode[i]), 32'(mIr[i] >> 26));
        check("rs", i, 32'(rs[i]), (mIr[i] >> 21) & 32'h1f);
        check("rt", i, 32'(rt[i]), (mIr[i] >> 16) & 32'h1f);
        check("rd", i, 32'(rd[i]), (mIr[i] >> 11) & 32'h1f);
        check("funct", i, 32'(funct[i]), mIr[i] & 32'h3f);
        check("imm", i, 32'(imm[i]), mIr[i] & 32'hffff);
    endtask

    task automatic step();
        @(posedge clk);
        edgeCnt++;
        for (int i = 0; i < 2; i++) modelEdge(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compareAll(i);
    endtask

    task automatic stepObs();
        step();
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                doneCnt[i]++;
                lastDone[i] = edgeCnt - tAcc;
            end
            if (memWe[i]) begin
                weCnt[i]++;
                if (firstWe[i] < 0) firstWe[i] = edgeCnt - tAcc;
            end
        end
    endtask

    task automatic clearObs();
        tAcc = edgeCnt + 1;
        for (int i = 0; i < 2; i++) begin
            doneCnt[i]  = 0;
            lastDone[i] = -1;
            weCnt[i]    = 0;
            firstWe[i]  = -1;
            nAcc[i]     = 0;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic doReset();
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mBusy[i]  = 1'b0;
            mErr[i]   = 1'b0;
            mIr[i]    = '0;
            mMdr[i]   = '0;
            mAddr[i]  = '0;
            mWdata[i] = '0;
        end
        #1;
        for (int i = 0; i < 2; i++) compareAll(i);
        #1 reset = 1'b0;
    endtask

    task automatic setReq(input int i, input logic v, input logic w, input logic f,
                          input logic [31:0] a, input logic [31:0] d);
        reqValid[i] = v;
        reqWrite[i] = w;
        reqFetch[i] = f;
        reqAddr[i]  = a;
        reqWdata[i] = d;
    endtask

    task automatic newReq(input int i);
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        setReq(i, 1'b1, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            setReq(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            memRdata[i] = '0;
        end
        @(negedge clk);
        doReset();

        // Fetch from 0x8.
        clearObs();
        for (int i = 0; i < 2; i++) begin
            setReq(i, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
            memRdata[i] = 32'h00851020;
        end
        stepObs();
        for (int i = 0; i < 2; i++) reqValid[i] = 1'b0;
        repeat (6) stepObs();
        check("fetch ir", 0, ir[0], 32'h00851020);
        check("fetch model ir", 0, mIr[0], 32'h00851020);
        check("fetch opcode", 0, 32'(opcode[0]), 32'h0);
        check("fetch funct", 0, 32'(funct[0]), 32'h20);
        check("fetch rs", 0, 32'(rs[0]), 32'd4);
        check("fetch rt", 0, 32'(rt[0]), 32'd5);
        check("fetch rd", 0, 32'(rd[0]), 32'd2);
        check("fetch mdr", 0, mdr[0], 32'h0);
        check("fetch done count", 0, 32'(doneCnt[0]), 32'd1);
        check("fetch done offset", 0, 32'(lastDone[0]), 32'd2);
        check("fetch done count", 1, 32'(doneCnt[1]), 32'd1);
        check("fetch done offset", 1, 32'(lastDone[1]), 32'd3);

        // Store 0xDEADBEEF to 0x40.
        clearObs();
        for (int i = 0; i < 2; i++) setReq(i, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        stepObs();
        for (int i = 0; i < 2; i++) reqValid[i] = 1'b0;
        repeat (6) stepObs();
        check("store we cycles", 0, 32'(weCnt[0]), 32'd1);
        check("store we start", 0, 32'(firstWe[0]), 32'd0);
        check("store done offset", 0, 32'(lastDone[0]), 32'd1);
        check("store we cycles", 1, 32'(weCnt[1]), 32'd2);
        check("store done offset", 1, 32'(lastDone[1]), 32'd2);
        check("store mem_addr", 0, memAddr[0], 32'h40);
        check("store mem_wdata", 0, memWdata[0], 32'hDEADBEEF);
        check("store ir kept", 1, ir[1], 32'h00851020);
        check("store mdr kept", 1, mdr[1], 32'h0);

        // Misaligned load from 0x42.
        clearObs();
        for (int i = 0; i < 2; i++) setReq(i, 1'b1, 1'b0, 1'b0, 32'h42, 32'h0);
        stepObs();
        check("misaligned addr_err", 0, 32'(addrErr[0]), 32'd1);
        check("misaligned ready", 0, 32'(reqReady[0]), 32'd1);
        for (int i = 0; i < 2; i++) reqValid[i] = 1'b0;
        repeat (4) stepObs();
        check("misaligned addr_err cleared", 0, 32'(addrErr[0]), 32'd0);
        check("misaligned done count", 1, 32'(doneCnt[1]), 32'd0);
        check("misaligned we count", 1, 32'(weCnt[1]), 32'd0);
        check("misaligned mem_addr kept", 0, memAddr[0], 32'h40);

        // Reset in the middle of a read wait.
        clearObs();
        for (int i = 0; i < 2; i++) begin
            setReq(i, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
            memRdata[i] = 32'h12345678;
        end
        stepObs();
        for (int i = 0; i < 2; i++) reqValid[i] = 1'b0;
        stepObs();
        doReset();
        check("abort ir", 0, ir[0], 32'h0);
        check("abort mdr", 1, mdr[1], 32'h0);
        check("abort mem_we", 0, 32'(memWe[0]), 32'd0);
        check("abort ready", 1, 32'(reqReady[1]), 32'd1);
        repeat (5) stepObs();
        check("abort done count", 0, 32'(doneCnt[0]), 32'd0);
        check("abort done count", 1, 32'(doneCnt[1]), 32'd0);

        // Load then store with req_valid held high throughout.
        clearObs();
        for (int i = 0; i < 2; i++) begin
            setReq(i, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
            memRdata[i] = 32'hCAFEF00D;
        end
        repeat (14) begin
            stepObs();
            for (int i = 0; i < 2; i++) begin
                if (accepted[i]) begin
                    nAcc[i]++;
                    if (nAcc[i] == 1) setReq(i, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0BADF00D);
                    else reqValid[i] = 1'b0;
                end
            end
        end
        check("b2b done count", 0, 32'(doneCnt[0]), 32'd2);
        check("b2b store start", 0, 32'(firstWe[0]), 32'd4);
        check("b2b done count", 1, 32'(doneCnt[1]), 32'd2);
        check("b2b store start", 1, 32'(firstWe[1]), 32'd5);
        check("b2b mdr", 0, mdr[0], 32'hCAFEF00D);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                memRdata[i] = $urandom;
                if (accepted[i]) begin
                    reqValid[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) newReq(i);
                end else if (!reqValid[i] && $urandom_range(0, 3) == 0) begin
                    newReq(i);
                end
            end
            if ($urandom_range(0, 199) == 0) doReset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
